// File: rtl/ifetch.sv
// Instruction fetch unit: one instruction in flight, stalls on back-pressure, redirects on flush/JALR.
// Optional IFETCH_JAL_PREDECODE_EN redirects pc to the JAL target at issue time.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_instr,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc,
   input  logic        jalr_valid,
   input  logic [31:0] jalr_target
);

   typedef enum logic [2:0] {
      StFetch,
      StWaitMem,
      StIssue,
      StWaitJalr,
      StDrop
   } state_e;

   localparam logic [6:0] OpJalr = 7'b1100111;
   localparam logic [6:0] OpJal  = 7'b1101111;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        dec_valid_q, dec_valid_d;
   logic [31:0] dec_instr_q, dec_instr_d;
   logic [31:0] dec_pc_q, dec_pc_d;
   logic [31:0] jal_pc;
   logic        stall;

`ifdef IFETCH_JAL_PREDECODE_EN
   logic [31:0] imm_j;
   assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                    instr_q[30:21], 1'b0};
   assign jal_pc = pc_q + imm_j;
`else
   assign jal_pc = pc_q + 32'd4;
`endif

   assign stall = rob_full | rs_full | lsb_full;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      dec_valid_d = 1'b0;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      if (!rdy_in) begin
         // Frozen: everything holds except the decoder pulse, which must not replay.
         dec_valid_d = 1'b0;
      end else if (flush_valid) begin
         pc_d = flush_pc;
         // An outstanding response must still be swallowed before fetching again.
         if ((state_q == StWaitMem || state_q == StDrop) && !ic_resp_valid) begin
            state_d = StDrop;
         end else begin
            state_d = StFetch;
         end
      end else begin
         case (state_q)
            StFetch: state_d = StWaitMem;
            StWaitMem: begin
               if (ic_resp_valid) begin
                  instr_d = ic_resp_instr;
                  state_d = StIssue;
               end
            end
            StIssue: begin
               if (!stall) begin
                  dec_valid_d = 1'b1;
                  dec_instr_d = instr_q;
                  dec_pc_d    = pc_q;
                  if (instr_q[6:0] == OpJalr) begin
                     state_d = StWaitJalr;
                  end else if (instr_q[6:0] == OpJal) begin
                     pc_d    = jal_pc;
                     state_d = StFetch;
                  end else begin
                     pc_d    = pc_q + 32'd4;
                     state_d = StFetch;
                  end
               end
            end
            StWaitJalr: begin
               if (jalr_valid) begin
                  pc_d    = {jalr_target[31:1], 1'b0};
                  state_d = StFetch;
               end
            end
            StDrop: begin
               if (ic_resp_valid) begin
                  state_d = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StFetch;
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0;
         dec_valid_q <= 1'b0;
         dec_instr_q <= 32'h0;
         dec_pc_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         dec_valid_q <= dec_valid_d;
         dec_instr_q <= dec_instr_d;
         dec_pc_q    <= dec_pc_d;
      end
   end

   // Request is gated by reset so nothing is requested while reset is held.
   assign ic_req_valid = !rst_in && (state_q == StFetch || state_q == StWaitMem);
   assign ic_req_addr  = ic_req_valid ? pc_q : 32'h0;
   assign dec_valid    = dec_valid_q & rdy_in;
   assign dec_instr    = dec_instr_q;
   assign dec_pc       = dec_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; expected JAL target follows IFETCH_JAL_PREDECODE_EN.
module tb_ifetch;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_instr;
   logic        rob_full, rs_full, lsb_full;
   logic        dec_valid;
   logic [31:0] dec_instr, dec_pc;
   logic        flush_valid;
   logic [31:0] flush_pc;
   logic        jalr_valid;
   logic [31:0] jalr_target;

   int n_tests = 0;
   int n_fail  = 0;

   ifetch #(.RESET_PC(32'h0)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .ic_req_valid  (ic_req_valid),
      .ic_req_addr   (ic_req_addr),
      .ic_resp_valid (ic_resp_valid),
      .ic_resp_instr (ic_resp_instr),
      .rob_full      (rob_full),
      .rs_full       (rs_full),
      .lsb_full      (lsb_full),
      .dec_valid     (dec_valid),
      .dec_instr     (dec_instr),
      .dec_pc        (dec_pc),
      .flush_valid   (flush_valid),
      .flush_pc      (flush_pc),
      .jalr_valid    (jalr_valid),
      .jalr_target   (jalr_target)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // From a visible FETCH cycle: two WAIT_MEM cycles, response, then ISSUE is visible.
   task automatic serve(input logic [31:0] instr);
      step();
      check("no_b2b_dec", 32'(dec_valid), 32'd0);
      check("req_held", 32'(ic_req_valid), 32'd1);
      step();
      ic_resp_valid = 1'b1;
      ic_resp_instr = instr;
      step();
      ic_resp_valid = 1'b0;
      check("issue_noreq", 32'(ic_req_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] jal_next;
`ifdef IFETCH_JAL_PREDECODE_EN
      jal_next = 32'd24;
`else
      jal_next = 32'd12;
`endif
      rst_in = 1'b1; rdy_in = 1'b1;
      ic_resp_valid = 1'b0; ic_resp_instr = 32'h0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      flush_valid = 1'b0; flush_pc = 32'h0;
      jalr_valid = 1'b0; jalr_target = 32'h0;
      repeat (2) step();
      check("rst_req_valid", 32'(ic_req_valid), 32'd0);
      check("rst_req_addr", ic_req_addr, 32'h0);
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      check("rst_dec_instr", dec_instr, 32'h0);
      check("rst_dec_pc", dec_pc, 32'h0);
      rst_in = 1'b0;
      #1;

      // Basic fetch of a NOP at pc 0
      check("f0_req_valid", 32'(ic_req_valid), 32'd1);
      check("f0_req_addr", ic_req_addr, 32'h0);
      serve(32'h00000013);
      step();
      check("f0_dec_valid", 32'(dec_valid), 32'd1);
      check("f0_dec_pc", dec_pc, 32'h0);
      check("f0_dec_instr", dec_instr, 32'h00000013);
      check("f0_next_addr", ic_req_addr, 32'h4);

      // Back-pressure for 5 cycles at pc 4
      rs_full = 1'b1;
      serve(32'h00100093);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_dec_valid", 32'(dec_valid), 32'd0);
         check("stall_noreq", 32'(ic_req_valid), 32'd0);
      end
      rs_full = 1'b0;
      step();
      check("rel_dec_valid", 32'(dec_valid), 32'd1);
      check("rel_dec_pc", dec_pc, 32'h4);
      check("rel_dec_instr", dec_instr, 32'h00100093);
      check("rel_next_addr", ic_req_addr, 32'h8);

      // JAL +16 at pc 8
      serve(32'h0100006F);
      step();
      check("jal_dec_valid", 32'(dec_valid), 32'd1);
      check("jal_dec_pc", dec_pc, 32'h8);
      check("jal_next_addr", ic_req_addr, jal_next);

      // Flush in WAIT_MEM; stale response arrives two cycles later
      step();
      flush_valid = 1'b1; flush_pc = 32'h40;
      step();
      flush_valid = 1'b0;
      check("drop_noreq", 32'(ic_req_valid), 32'd0);
      step();
      ic_resp_valid = 1'b1; ic_resp_instr = 32'h00000013;
      step();
      ic_resp_valid = 1'b0;
      check("drop_dec_valid", 32'(dec_valid), 32'd0);
      check("drop_req_valid", 32'(ic_req_valid), 32'd1);
      check("drop_next_addr", ic_req_addr, 32'h40);
      step();
      check("drop_dec_valid2", 32'(dec_valid), 32'd0);

      // Flush coinciding with a response: response discarded
      flush_valid = 1'b1; flush_pc = 32'h20;
      ic_resp_valid = 1'b1; ic_resp_instr = 32'h00000013;
      step();
      flush_valid = 1'b0; ic_resp_valid = 1'b0;
      check("fr_dec_valid", 32'(dec_valid), 32'd0);
      check("fr_next_addr", ic_req_addr, 32'h20);

      // JALR at 0x20 waits for the resolved target
      serve(32'h000080E7);
      step();
      check("jalr_dec_valid", 32'(dec_valid), 32'd1);
      check("jalr_dec_pc", dec_pc, 32'h20);
      check("jalr_noreq", 32'(ic_req_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("jalr_wait_noreq", 32'(ic_req_valid), 32'd0);
      end
      jalr_valid = 1'b1; jalr_target = 32'h101;
      step();
      jalr_valid = 1'b0;
      check("jalr_req_valid", 32'(ic_req_valid), 32'd1);
      check("jalr_next_addr", ic_req_addr, 32'h100);

      // Wrap at top of address space, with a 3-cycle freeze in WAIT_MEM
      step();
      flush_valid = 1'b1; flush_pc = 32'hFFFFFFFC;
      ic_resp_valid = 1'b1; ic_resp_instr = 32'h00000013;
      step();
      flush_valid = 1'b0; ic_resp_valid = 1'b0;
      check("wrap_addr", ic_req_addr, 32'hFFFFFFFC);
      step();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("frz_req_valid", 32'(ic_req_valid), 32'd1);
         check("frz_req_addr", ic_req_addr, 32'hFFFFFFFC);
         check("frz_dec_valid", 32'(dec_valid), 32'd0);
      end
      rdy_in = 1'b1;
      step();
      ic_resp_valid = 1'b1; ic_resp_instr = 32'h00000013;
      step();
      ic_resp_valid = 1'b0;
      step();
      check("wrap_dec_valid", 32'(dec_valid), 32'd1);
      check("wrap_dec_pc", dec_pc, 32'hFFFFFFFC);
      check("wrap_next_addr", ic_req_addr, 32'h0);

      // Reset mid-transaction
      step();
      rst_in = 1'b1;
      #1;
      check("mrst_req_valid", 32'(ic_req_valid), 32'd0);
      check("mrst_dec_pc", dec_pc, 32'h0);
      step();
      rst_in = 1'b0;
      #1;
      check("mrst_refetch", 32'(ic_req_valid), 32'd1);
      check("mrst_addr", ic_req_addr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
